// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external ALU among NREQ requesters; latency grant+ISSUE+ALU cycles+RESP.
// Backpressure: requesters hold req until ack; requests are sampled only in IDLE, one transaction in flight.
module alu_arbiter #(
    parameter int WIDTH   = 16,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*3-1:0]     req_op,
    output logic [NREQ-1:0]       ack,
    output logic [NREQ-1:0]       resp_valid,
    output logic [WIDTH-1:0]      resp_result,
    output logic                  resp_err,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    output logic [2:0]            alu_op,
    output logic                  alu_start,
    input  logic                  alu_done,
    input  logic [WIDTH-1:0]      alu_result,
    output logic                  busy
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state_q, state_d;
    logic [1:0]       rst_sync;
    logic             rst_i_n;
    logic [PW-1:0]    ptr_q, gnt_q, gnt;
    logic [WIDTH-1:0] a_q, b_q, res_q, sel_a, sel_b;
    logic [2:0]       op_q, sel_op;
    logic             err_q, found, op_legal, timed_out;
    logic [CW-1:0]    cnt_q;
    int               sidx;

    // Assert asynchronously, release on the second edge so the core always leaves reset from a clean IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_i_n = rst_sync[1];

    always_comb begin
        found = 1'b0;
        gnt   = '0;
        sidx  = 0;
        for (int k = 0; k < NREQ; k++) begin
            sidx = (int'(ptr_q) + k) % NREQ;
            if (!found && req[PW'(sidx)]) begin
                found = 1'b1;
                gnt   = PW'(sidx);
            end
        end
    end

    assign sel_a     = req_a[gnt*WIDTH +: WIDTH];
    assign sel_b     = req_b[gnt*WIDTH +: WIDTH];
    assign sel_op    = req_op[gnt*3 +: 3];
    assign op_legal  = (sel_op <= 3'd5);
    assign timed_out = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found) state_d = op_legal ? ISSUE : RESP;
            ISSUE:   state_d = WAIT;
            WAIT:    if (alu_done || timed_out) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (found) begin
                    gnt_q <= gnt;
                    a_q   <= sel_a;
                    b_q   <= sel_b;
                    op_q  <= sel_op;
                    err_q <= !op_legal;
                    res_q <= '0;
                end
                ISSUE: cnt_q <= '0;
                WAIT: begin
                    // A completion in the last allowed cycle still wins over the timeout.
                    if (alu_done) begin
                        res_q <= alu_result;
                        err_q <= 1'b0;
                    end else if (timed_out) begin
                        res_q <= '0;
                        err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RESP: ptr_q <= (gnt_q == PW'(NREQ - 1)) ? '0 : gnt_q + PW'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        ack         = '0;
        resp_valid  = '0;
        resp_result = '0;
        resp_err    = 1'b0;
        if (state_q == IDLE && found && rst_i_n) ack = NREQ'(1) << gnt;
        if (state_q == RESP) begin
            resp_valid  = NREQ'(1) << gnt_q;
            resp_result = res_q;
            resp_err    = err_q;
        end
    end

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_op    = op_q;
    assign alu_start = (state_q == ISSUE);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: scoreboard queue of expected responses, popped by a monitor on resp_valid.
module tb_alu_arbiter;
    localparam int W  = 16;
    localparam int N  = 4;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_a, req_b;
    logic [N*3-1:0] req_op;
    logic [N-1:0]   ack, resp_valid;
    logic [W-1:0]   resp_result, alu_a, alu_b, alu_result;
    logic           resp_err, alu_start, alu_done, busy;
    logic [2:0]     alu_op;

    typedef struct {
        int           idx;
        logic [W-1:0] res;
        logic         err;
    } exp_t;

    exp_t exp_q[$];
    int   ack_log[$];
    int   checks = 0, failures = 0, cyc = 0;
    int   ack_cnt = 0, start_cnt = 0, resp_cnt = 0;
    int   ack_cyc = 0, start_cyc = 0, resp_cyc = 0;
    int   alu_lat = 1;
    logic alu_hang = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_arbiter #(.WIDTH(W), .NREQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .ack(ack), .resp_valid(resp_valid), .resp_result(resp_result), .resp_err(resp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
        .alu_done(alu_done), .alu_result(alu_result), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int oh2idx(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) if (v[k]) return k;
        return -1;
    endfunction

    function automatic logic [W-1:0] alu_calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return ~(a | b);
            3'd5:    return a ^ b;
            default: return '0;
        endcase
    endfunction

    // Monitor: logs grants/starts and scores every response against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ack != 0) begin
                ack_cnt++;
                ack_cyc = cyc;
                ack_log.push_back(oh2idx(ack));
            end
            if (alu_start) begin
                start_cnt++;
                start_cyc = cyc;
            end
            if (resp_valid != 0) begin
                resp_cnt++;
                resp_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("resp_unexpected", 32'(resp_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_idx", 32'(resp_valid), 32'(1) << e.idx);
                    check("resp_result", 32'(resp_result), 32'(e.res));
                    check("resp_err", 32'(resp_err), 32'(e.err));
                end
            end
        end
    end

    // ALU model: done alu_lat cycles into WAIT, or never when hung.
    initial begin
        alu_done   = 1'b0;
        alu_result = '0;
        forever begin
            @(negedge clk);
            if (alu_start && !alu_hang) begin
                @(posedge clk);
                repeat (alu_lat - 1) @(posedge clk);
                #1;
                alu_done   = 1'b1;
                alu_result = alu_calc(alu_a, alu_b, alu_op);
                @(posedge clk);
                #1;
                alu_done   = 1'b0;
            end
        end
    end

    task automatic wait_ack(input int n, input string nm);
        int k = 0;
        while (ack_cnt < n && k < 300) begin
            @(posedge clk);
            k++;
        end
        check({nm, "_ack_seen"}, 32'(ack_cnt >= n), 32'd1);
    endtask

    task automatic wait_resp(input int n, input string nm);
        int k = 0;
        while (resp_cnt < n && k < 300) begin
            @(posedge clk);
            k++;
        end
        check({nm, "_resp_seen"}, 32'(resp_cnt >= n), 32'd1);
    endtask

    task automatic wait_start(input int n, input string nm);
        int k = 0;
        while (start_cnt < n && k < 300) begin
            @(posedge clk);
            k++;
        end
        check({nm, "_start_seen"}, 32'(start_cnt >= n), 32'd1);
    endtask

    task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_op[i*3 +: 3] = op;
        req[i] = 1'b1;
    endtask

    task automatic single(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                          input logic [W-1:0] res, input logic err, input string nm);
        int a0 = ack_cnt;
        int r0 = resp_cnt;
        exp_t e;
        @(posedge clk);
        #1;
        e.idx = i; e.res = res; e.err = err;
        exp_q.push_back(e);
        issue(i, a, b, op);
        wait_ack(a0 + 1, nm);
        #1;
        req[i] = 1'b0;
        wait_resp(r0 + 1, nm);
        check({nm, "_ack_count"}, 32'(ack_cnt - a0), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int   s0, r0, a0, l0;
        int   ord[5];
        exp_t e;
        ord = '{0, 1, 2, 3, 0};
        req = '0; req_a = '0; req_b = '0; req_op = '0;
        req[1] = 1'b1;

        @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_alu_start", 32'(alu_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_resp_result", 32'(resp_result), 32'd0);
        check("rst_alu_ops", {alu_a, alu_b} | 32'(alu_op), 32'd0);
        req = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);

        alu_lat = 2;
        s0 = start_cnt;
        single(0, 16'h0005, 16'h0003, 3'd0, 16'h0008, 1'b0, "add");
        check("add_starts", 32'(start_cnt - s0), 32'd1);
        check("add_latency", 32'(resp_cyc - ack_cyc), 32'd4);

        alu_lat = 1;
        single(3, 16'h0000, 16'h0001, 3'd1, 16'hFFFF, 1'b0, "sub_wrap");
        check("sub_latency", 32'(resp_cyc - ack_cyc), 32'd3);

        s0 = start_cnt;
        single(2, 16'h1234, 16'h5678, 3'd6, 16'h0000, 1'b1, "illegal");
        check("illegal_no_start", 32'(start_cnt - s0), 32'd0);
        check("illegal_latency", 32'(resp_cyc - ack_cyc), 32'd1);

        alu_hang = 1'b1;
        single(1, 16'hFFFF, 16'h00FF, 3'd2, 16'h0000, 1'b1, "timeout");
        check("timeout_latency", 32'(resp_cyc - start_cyc), 32'(TO + 1));
        alu_hang = 1'b0;
        single(2, 16'h00F0, 16'h0FF0, 3'd5, 16'h0F00, 1'b0, "after_timeout");

        alu_hang = 1'b1;
        r0 = resp_cnt;
        s0 = start_cnt;
        @(posedge clk);
        #1;
        issue(0, 16'hAAAA, 16'h5555, 3'd3);
        wait_start(s0 + 1, "midrst");
        #1;
        req[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_alu_a", 32'(alu_a), 32'd0);
        check("midrst_alu_b", 32'(alu_b), 32'd0);
        check("midrst_alu_op", 32'(alu_op), 32'd0);
        check("midrst_resp_valid", 32'(resp_valid), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        alu_hang = 1'b0;
        repeat (5) @(posedge clk);
        check("midrst_no_resp", 32'(resp_cnt), 32'(r0));

        @(posedge clk);
        #1;
        a0 = ack_cnt;
        r0 = resp_cnt;
        l0 = ack_log.size();
        for (int k = 0; k < 5; k++) begin
            e.idx = ord[k];
            case (ord[k])
                0: e.res = 16'h0003;
                1: e.res = 16'h0007;
                2: e.res = 16'h000F;
                default: e.res = 16'hF00F;
            endcase
            e.err = 1'b0;
            exp_q.push_back(e);
        end
        issue(0, 16'h0001, 16'h0002, 3'd0);
        issue(1, 16'h000A, 16'h0003, 3'd1);
        issue(2, 16'h0F0F, 16'h00FF, 3'd2);
        issue(3, 16'h00F0, 16'h0F00, 3'd4);
        wait_ack(a0 + 5, "rr");
        #1;
        req = '0;
        wait_resp(r0 + 5, "rr");
        check("rr_grants", 32'(ack_log.size() - l0), 32'd5);
        for (int k = 0; k < 5; k++)
            if (l0 + k < ack_log.size()) check("rr_order", 32'(ack_log[l0 + k]), 32'(ord[k]));
        repeat (3) @(posedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
